// File: rtl/exec_sequencer.sv
// Command sequencer for the SIMD execute unit: queues commands in a small FIFO,
// issues them one at a time and returns a tagged response with a timeout guard.
module exec_sequencer #(
  parameter int ALU_NUM = 24,
  parameter int IMM_W   = 5,
  parameter int TAG_W   = 4,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [3:0]         cmd_opcode,
  input  logic [ALU_NUM-1:0] cmd_mask,
  input  logic [IMM_W-1:0]   cmd_imm,
  input  logic [TAG_W-1:0]   cmd_tag,
  output logic [ALU_NUM-1:0] exe_enable_alu,
  output logic [3:0]         exe_opcode,
  output logic [IMM_W-1:0]   exe_imm,
  input  logic               exe_valid,
  input  logic               exe_zero,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [TAG_W-1:0]   rsp_tag,
  output logic               rsp_zero,
  output logic               rsp_err,
  output logic               busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);
  localparam logic [PW:0]   FULL_CNT = (PW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t             state_q, state_d;
  logic [3:0]         fifo_op_q   [DEPTH];
  logic [3:0]         fifo_op_d   [DEPTH];
  logic [ALU_NUM-1:0] fifo_mask_q [DEPTH];
  logic [ALU_NUM-1:0] fifo_mask_d [DEPTH];
  logic [IMM_W-1:0]   fifo_imm_q  [DEPTH];
  logic [IMM_W-1:0]   fifo_imm_d  [DEPTH];
  logic [TAG_W-1:0]   fifo_tag_q  [DEPTH];
  logic [TAG_W-1:0]   fifo_tag_d  [DEPTH];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]        count_q, count_d;
  logic [ALU_NUM-1:0] cur_mask_q, cur_mask_d;
  logic [TAG_W-1:0]   cur_tag_q, cur_tag_d;
  logic [3:0]         exe_opcode_q, exe_opcode_d;
  logic [IMM_W-1:0]   exe_imm_q, exe_imm_d;
  logic [CW-1:0]      timer_q, timer_d;
  logic [TAG_W-1:0]   rsp_tag_q, rsp_tag_d;
  logic               rsp_zero_q, rsp_zero_d;
  logic               rsp_err_q, rsp_err_d;
  logic               push, pop;

  // Ready comes from the registered count only, so a full FIFO never accepts
  // even when the head is popped in the same cycle.
  assign cmd_ready      = (count_q != FULL_CNT);
  assign exe_enable_alu = (state_q == EXEC) ? cur_mask_q : '0;
  assign exe_opcode     = exe_opcode_q;
  assign exe_imm        = exe_imm_q;
  assign rsp_valid      = (state_q == RESP);
  assign rsp_tag        = rsp_tag_q;
  assign rsp_zero       = rsp_zero_q;
  assign rsp_err        = rsp_err_q;
  assign busy           = (state_q != IDLE) || (count_q != '0);

  always_comb begin
    push         = cmd_valid && cmd_ready;
    pop          = 1'b0;
    state_d      = state_q;
    cur_mask_d   = cur_mask_q;
    cur_tag_d    = cur_tag_q;
    exe_opcode_d = exe_opcode_q;
    exe_imm_d    = exe_imm_q;
    timer_d      = timer_q;
    rsp_tag_d    = rsp_tag_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_err_d    = rsp_err_q;
    fifo_op_d    = fifo_op_q;
    fifo_mask_d  = fifo_mask_q;
    fifo_imm_d   = fifo_imm_q;
    fifo_tag_d   = fifo_tag_q;

    if (push) begin
      fifo_op_d[wr_ptr_q]   = cmd_opcode;
      fifo_mask_d[wr_ptr_q] = cmd_mask;
      fifo_imm_d[wr_ptr_q]  = cmd_imm;
      fifo_tag_d[wr_ptr_q]  = cmd_tag;
    end

    unique case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop        = 1'b1;
          cur_mask_d = fifo_mask_q[rd_ptr_q];
          cur_tag_d  = fifo_tag_q[rd_ptr_q];
          timer_d    = '0;
          // An empty mask never reaches the unit; it is answered as an error.
          if (fifo_mask_q[rd_ptr_q] != '0) begin
            state_d      = EXEC;
            exe_opcode_d = fifo_op_q[rd_ptr_q];
            exe_imm_d    = fifo_imm_q[rd_ptr_q];
          end else begin
            state_d    = RESP;
            rsp_tag_d  = fifo_tag_q[rd_ptr_q];
            rsp_zero_d = 1'b0;
            rsp_err_d  = 1'b1;
          end
        end
      end
      EXEC: begin
        if (exe_valid) begin
          state_d    = RESP;
          rsp_tag_d  = cur_tag_q;
          rsp_zero_d = exe_zero;
          rsp_err_d  = 1'b0;
        end else if (timer_q == TMO_LAST) begin
          state_d    = RESP;
          rsp_tag_d  = cur_tag_q;
          rsp_zero_d = 1'b0;
          rsp_err_d  = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + (PW + 1)'(push) - (PW + 1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      cur_mask_q   <= '0;
      cur_tag_q    <= '0;
      exe_opcode_q <= '0;
      exe_imm_q    <= '0;
      timer_q      <= '0;
      rsp_tag_q    <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      cur_mask_q   <= cur_mask_d;
      cur_tag_q    <= cur_tag_d;
      exe_opcode_q <= exe_opcode_d;
      exe_imm_q    <= exe_imm_d;
      timer_q      <= timer_d;
      rsp_tag_q    <= rsp_tag_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  // Storage needs no reset: the count alone decides which entries are live.
  always_ff @(posedge clk) begin
    fifo_op_q   <= fifo_op_d;
    fifo_mask_q <= fifo_mask_d;
    fifo_imm_q  <= fifo_imm_d;
    fifo_tag_q  <= fifo_tag_d;
  end

endmodule
